npc_pc_unit: RTL and testbench
==============================

Name: npc_pc_unit

Overview:
- Fetch-stage PC register plus D-stage next-PC resolution for the pipelined MIPS core.
- Generalises the single-branch next-PC logic to six compare-branch kinds, j/jal and jr/jalr.
- Holds the PC across stalls. A redirect resolved while stalled is buffered and applied when the stall releases.
- Sits between the D-stage comparator/decoder and the F-stage instruction memory.

Parameters:
- WIDTH, 32, PC and operand width (≥ 28).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- STAT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hold the PC this cycle (F/D freeze)
- br_op  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 none
- jmp_op  in  2  00 none, 01 j/jal, 10 jr/jalr, 11 none
- rs_val  in  WIDTH  forwarded rs operand (D stage)
- rt_val  in  WIDTH  forwarded rt operand (D stage)
- imm16  in  16  branch offset
- instr_index  in  26  jump index
- pc4_d  in  WIDTH  PC+4 of the D-stage instruction
- pc_f  out  WIDTH  registered fetch PC
- pc4_f  out  WIDTH  pc_f+4, combinational
- redirect_d  out  1  D-stage control transfer taken, combinational
- target_d  out  WIDTH  selected target, combinational
- link_d  out  WIDTH  pc4_d+4, the jal/jalr return address (delay slot)
- pc_misalign_f  out  1  pc_f[1:0] != 0, combinational
- stat_taken, stat_branches  out  STAT_W  optional counters (see below)

Behaviour:
- Branch target: pc4_d + (sign-extend(imm16) << 2), truncated to WIDTH.
- Jump target: {pc4_d[WIDTH-1:28], instr_index, 2'b00}.
- Register-jump target: rs_val.
- Branch conditions use signed compares on rs_val:
  - beq: rs == rt
  - bne: rs != rt
  - blez: rs <= 0
  - bgtz: rs > 0
  - bltz: rs < 0
  - bgez: rs >= 0
- redirect_d = (jmp_op ∈ {01,10}) OR (br_op ∈ 001..110 AND condition true).
- Jump has priority if jmp_op and br_op are both non-none (decoder error). target_d then shows the jump target.
- When redirect_d = 0, target_d = pc4_d + 4.
- State: pc_f register; pend_v flag; pend_tgt register (WIDTH).
- Reset (async, reset_n = 0): pc_f = RESET_PC, pend_v = 0, pend_tgt = 0, counters = 0. All outputs follow immediately.
- Per rising clk, in priority order:
  1. stall = 0 and redirect_d = 1: pc_f ← target_d; pend_v ← 0.
  2. stall = 0 and pend_v = 1: pc_f ← pend_tgt; pend_v ← 0.
  3. stall = 0: pc_f ← pc_f + 4.
  4. stall = 1 and redirect_d = 1: pc_f holds; pend_v ← 1; pend_tgt ← target_d (the newest redirect overwrites any older pending one).
  5. stall = 1 otherwise: everything holds.
- Latency: a redirect visible in cycle N sets pc_f in cycle N+1. The delay-slot instruction, fetched at pc_f in cycle N, is never squashed.
- Address arithmetic wraps modulo 2^WIDTH with no carry flag. pc_f = all-ones minus 3 increments to 0.
- A misaligned target is loaded as-is. pc_misalign_f flags it for the exception logic; the unit does not trap.
- reset_n asserted mid-stall or with pend_v set discards the pending target.

Optional Feature:
- Macro: NPC_BRANCH_STATS_EN.
- Defined:
  - stat_branches increments on each clk with stall = 0 and br_op ∈ 001..110.
  - stat_taken increments on each such clk where the condition is true.
  - Both saturate at all-ones and reset to 0.
  - Stalled cycles are not counted, so held instructions are counted once.
- Not defined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset: hold reset_n = 0, release → pc_f = 0x3000. Three unstalled clocks → 0x3004, 0x3008, 0x300C. Reassert reset_n asynchronously between edges → pc_f = 0x3000 immediately.
- beq taken/not-taken: pc4_d = 0x3008, imm16 = 0xFFFE, rs = rt = 5 → target_d = 0x3000, next pc_f = 0x3000. Then rt = 6 → redirect_d = 0, pc_f steps by 4.
- Signed branches: rs = 0x8000_0000:
  - bltz → taken, blez → taken, bgtz → not taken, bgez → not taken.
  - rs = 0 with bgez → taken.
- Jumps:
  - j, pc4_d = 0x0000_3010, instr_index = 0x0000C40 → pc_f = 0x0000_3100.
  - jr with rs = 0x0000_3404 → pc_f = 0x3404.
  - link_d = 0x3014 in both cases.
- Stall with pending: stall = 1 for 3 cycles, beq taken to 0x3040 in the first → pc_f holds and pend_v = 1. Release stall with br_op = 0 → pc_f = 0x3040 next edge and pend_v = 0. Repeat with a new redirect to 0x3080 on the release cycle → pc_f = 0x3080.
- Stats (NPC_BRANCH_STATS_EN): 4 unstalled branches, 3 taken, plus 2 stalled-cycle repeats → stat_branches = 4, stat_taken = 3. With STAT_W = 2, 5 branches → saturates at 3. Without the macro, both outputs read 0.

Source files
------------

// File: rtl/npc_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : npc_pc_unit
// Brief    : Fetch-stage PC register with D-stage next-PC resolution.
//            Resolves six compare-branch kinds, j/jal and jr/jalr, holds the
//            PC across stalls and buffers a redirect seen while stalled until
//            the stall releases.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   stall          hold the PC this cycle (F/D freeze)
//   br_op[2:0]     001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez
//   jmp_op[1:0]    01 j/jal, 10 jr/jalr
//   rs_val/rt_val  forwarded D-stage operands
//   imm16          branch offset (words)
//   instr_index    jump index
//   pc4_d          PC+4 of the D-stage instruction
//   pc_f           registered fetch PC
//   pc4_f          pc_f + 4
//   redirect_d     D-stage control transfer taken
//   target_d       selected next-PC target (pc4_d + 4 when not redirecting)
//   link_d         jal/jalr return address (past the delay slot)
//   pc_misalign_f  pc_f not word aligned
//   stat_taken     taken-branch counter (optional)
//   stat_branches  executed-branch counter (optional)
// Build option
//   NPC_BRANCH_STATS_EN : when defined, the saturating branch statistics
//                         counters are built; otherwise both outputs are 0.
// ============================================================================
module npc_pc_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter int               STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic [2:0]        br_op,
    input  logic [1:0]        jmp_op,
    input  logic [WIDTH-1:0]  rs_val,
    input  logic [WIDTH-1:0]  rt_val,
    input  logic [15:0]       imm16,
    input  logic [25:0]       instr_index,
    input  logic [WIDTH-1:0]  pc4_d,
    output logic [WIDTH-1:0]  pc_f,
    output logic [WIDTH-1:0]  pc4_f,
    output logic              redirect_d,
    output logic [WIDTH-1:0]  target_d,
    output logic [WIDTH-1:0]  link_d,
    output logic              pc_misalign_f,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_branches
);

    localparam logic [WIDTH-1:0] c_four    = WIDTH'(4);
    localparam int               c_ext_w   = WIDTH - 18;

    logic [WIDTH-1:0] r_pc_f;
    logic             r_pend_v;
    logic [WIDTH-1:0] r_pend_tgt;

    logic [WIDTH-1:0] w_br_target;
    logic [WIDTH-1:0] w_jmp_target;
    logic             w_br_valid;
    logic             w_br_cond;
    logic             w_is_jump;
    logic             w_redirect;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_link;

    // Sign-extended word offset; wraps naturally at WIDTH bits.
    assign w_br_target = pc4_d + {{c_ext_w{imm16[15]}}, imm16, 2'b00};
    assign w_link      = pc4_d + c_four;

    // Region bits above the 28-bit jump field only exist when WIDTH > 28.
    generate
        if (WIDTH > 28) begin : g_jmp_region
            assign w_jmp_target = {pc4_d[WIDTH-1:28], instr_index, 2'b00};
        end else begin : g_jmp_flat
            assign w_jmp_target = {instr_index, 2'b00};
        end
    endgenerate

    always_comb begin
        w_br_valid = 1'b1;
        w_br_cond  = 1'b0;
        case (br_op)
            3'b001:  w_br_cond = (rs_val == rt_val);
            3'b010:  w_br_cond = (rs_val != rt_val);
            3'b011:  w_br_cond = ($signed(rs_val) <= $signed({WIDTH{1'b0}}));
            3'b100:  w_br_cond = ($signed(rs_val) >  $signed({WIDTH{1'b0}}));
            3'b101:  w_br_cond = rs_val[WIDTH-1];
            3'b110:  w_br_cond = ~rs_val[WIDTH-1];
            default: w_br_valid = 1'b0;
        endcase
    end

    assign w_is_jump  = (jmp_op == 2'b01) || (jmp_op == 2'b10);
    assign w_redirect = w_is_jump || (w_br_valid && w_br_cond);

    // Jumps win over a simultaneous branch (a decoder error case).
    always_comb begin
        w_target = w_link;
        if (jmp_op == 2'b01)
            w_target = w_jmp_target;
        else if (jmp_op == 2'b10)
            w_target = rs_val;
        else if (w_br_valid && w_br_cond)
            w_target = w_br_target;
    end

    // A redirect arriving during a stall is parked and replayed on release;
    // a fresh redirect on the release cycle supersedes the parked one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc_f     <= RESET_PC;
            r_pend_v   <= 1'b0;
            r_pend_tgt <= '0;
        end else if (!stall) begin
            if (w_redirect)
                r_pc_f <= w_target;
            else if (r_pend_v)
                r_pc_f <= r_pend_tgt;
            else
                r_pc_f <= r_pc_f + c_four;
            r_pend_v <= 1'b0;
        end else if (w_redirect) begin
            r_pend_v   <= 1'b1;
            r_pend_tgt <= w_target;
        end
    end

`ifdef NPC_BRANCH_STATS_EN
    logic [STAT_W-1:0] r_stat_taken;
    logic [STAT_W-1:0] r_stat_branches;

    // Only unstalled cycles count, so a held instruction is counted once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_taken    <= '0;
            r_stat_branches <= '0;
        end else if (!stall && w_br_valid) begin
            if (r_stat_branches != {STAT_W{1'b1}})
                r_stat_branches <= r_stat_branches + STAT_W'(1);
            if (w_br_cond && (r_stat_taken != {STAT_W{1'b1}}))
                r_stat_taken <= r_stat_taken + STAT_W'(1);
        end
    end

    assign stat_taken    = r_stat_taken;
    assign stat_branches = r_stat_branches;
`else
    assign stat_taken    = '0;
    assign stat_branches = '0;
`endif

    assign pc_f          = r_pc_f;
    assign pc4_f         = r_pc_f + c_four;
    assign redirect_d    = w_redirect;
    assign target_d      = w_target;
    assign link_d        = w_link;
    assign pc_misalign_f = |r_pc_f[1:0];

endmodule
`default_nettype wire

// File: tb/tb_npc_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_npc_pc_unit
// Brief    : Directed self-checking bench for npc_pc_unit (reset, branches,
//            jumps, stall buffering, wrap/misalign, optional statistics).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_npc_pc_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [2:0]  br_op;
    logic [1:0]  jmp_op;
    logic [31:0] rs_val, rt_val, pc4_d;
    logic [15:0] imm16;
    logic [25:0] instr_index;

    logic [31:0] pc_f, pc4_f, target_d, link_d;
    logic        redirect_d, pc_misalign_f;
    logic [15:0] stat_taken, stat_branches;

    logic [31:0] s_pc_f, s_pc4_f, s_target_d, s_link_d;
    logic        s_redirect_d, s_pc_misalign_f;
    logic [1:0]  s_stat_taken, s_stat_branches;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    npc_pc_unit #(.WIDTH(32), .RESET_PC(32'h0000_3000), .STAT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .br_op(br_op),
        .jmp_op(jmp_op), .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16),
        .instr_index(instr_index), .pc4_d(pc4_d), .pc_f(pc_f), .pc4_f(pc4_f),
        .redirect_d(redirect_d), .target_d(target_d), .link_d(link_d),
        .pc_misalign_f(pc_misalign_f), .stat_taken(stat_taken),
        .stat_branches(stat_branches)
    );

    npc_pc_unit #(.WIDTH(32), .RESET_PC(32'h0000_3000), .STAT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .stall(stall), .br_op(br_op),
        .jmp_op(jmp_op), .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16),
        .instr_index(instr_index), .pc4_d(pc4_d), .pc_f(s_pc_f), .pc4_f(s_pc4_f),
        .redirect_d(s_redirect_d), .target_d(s_target_d), .link_d(s_link_d),
        .pc_misalign_f(s_pc_misalign_f), .stat_taken(s_stat_taken),
        .stat_branches(s_stat_branches)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; br_op = 3'b000; jmp_op = 2'b00;
    endtask

    // Pulse reset between edges; leaves pc_f at 0x3000, one edge away.
    task automatic pulse_reset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        idle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; idle();
        rs_val = '0; rt_val = '0; pc4_d = '0; imm16 = '0; instr_index = '0;
        #12;
        checks++; if (pc_f !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_f, 32'h3000); end
        checks++; if (stat_branches !== 16'd0 || stat_taken !== 16'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_branches, stat_taken); end
        reset_n = 1'b1;
        step();
        checks++; if (pc_f !== 32'h3004) begin errors++; $display("FAIL inc1: got %h expected %h", pc_f, 32'h3004); end
        step();
        checks++; if (pc_f !== 32'h3008) begin errors++; $display("FAIL inc2: got %h expected %h", pc_f, 32'h3008); end
        step();
        checks++; if (pc_f !== 32'h300C) begin errors++; $display("FAIL inc3: got %h expected %h", pc_f, 32'h300C); end
        checks++; if (pc4_f !== 32'h3010) begin errors++; $display("FAIL pc4_f: got %h expected %h", pc4_f, 32'h3010); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (pc_f !== 32'h3000) begin errors++; $display("FAIL async_reset: got %h expected %h", pc_f, 32'h3000); end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_beq();
        idle();
        pc4_d = 32'h3008; imm16 = 16'hFFFE; rs_val = 32'd5; rt_val = 32'd5; br_op = 3'b001;
        #1;
        checks++; if (redirect_d !== 1'b1 || target_d !== 32'h3000) begin errors++; $display("FAIL beq_taken_comb: got %b/%h expected 1/%h", redirect_d, target_d, 32'h3000); end
        step();
        checks++; if (pc_f !== 32'h3000) begin errors++; $display("FAIL beq_taken_pc: got %h expected %h", pc_f, 32'h3000); end
        rt_val = 32'd6;
        #1;
        checks++; if (redirect_d !== 1'b0 || target_d !== 32'h300C) begin errors++; $display("FAIL beq_not_comb: got %b/%h expected 0/%h", redirect_d, target_d, 32'h300C); end
        step();
        checks++; if (pc_f !== 32'h3004) begin errors++; $display("FAIL beq_not_pc: got %h expected %h", pc_f, 32'h3004); end
        br_op = 3'b010;
        #1;
        checks++; if (redirect_d !== 1'b1) begin errors++; $display("FAIL bne_taken: got %b expected 1", redirect_d); end
        idle();
    endtask

    task automatic test_signed();
        idle();
        rs_val = 32'h8000_0000; rt_val = '0;
        br_op = 3'b101; #1;
        checks++; if (redirect_d !== 1'b1) begin errors++; $display("FAIL bltz_neg: got %b expected 1", redirect_d); end
        br_op = 3'b011; #1;
        checks++; if (redirect_d !== 1'b1) begin errors++; $display("FAIL blez_neg: got %b expected 1", redirect_d); end
        br_op = 3'b100; #1;
        checks++; if (redirect_d !== 1'b0) begin errors++; $display("FAIL bgtz_neg: got %b expected 0", redirect_d); end
        br_op = 3'b110; #1;
        checks++; if (redirect_d !== 1'b0) begin errors++; $display("FAIL bgez_neg: got %b expected 0", redirect_d); end
        rs_val = 32'd0; #1;
        checks++; if (redirect_d !== 1'b1) begin errors++; $display("FAIL bgez_zero: got %b expected 1", redirect_d); end
        br_op = 3'b100; #1;
        checks++; if (redirect_d !== 1'b0) begin errors++; $display("FAIL bgtz_zero: got %b expected 0", redirect_d); end
        br_op = 3'b011; #1;
        checks++; if (redirect_d !== 1'b1) begin errors++; $display("FAIL blez_zero: got %b expected 1", redirect_d); end
        br_op = 3'b111; #1;
        checks++; if (redirect_d !== 1'b0) begin errors++; $display("FAIL brop_111: got %b expected 0", redirect_d); end
        idle();
    endtask

    task automatic test_jumps();
        idle();
        pc4_d = 32'h3010; instr_index = 26'h0000C40; jmp_op = 2'b01;
        #1;
        checks++; if (link_d !== 32'h3014) begin errors++; $display("FAIL j_link: got %h expected %h", link_d, 32'h3014); end
        step();
        checks++; if (pc_f !== 32'h3100) begin errors++; $display("FAIL j_pc: got %h expected %h", pc_f, 32'h3100); end
        rs_val = 32'h3404; jmp_op = 2'b10;
        #1;
        checks++; if (link_d !== 32'h3014 || target_d !== 32'h3404) begin errors++; $display("FAIL jr_comb: got %h/%h expected %h/%h", link_d, target_d, 32'h3014, 32'h3404); end
        step();
        checks++; if (pc_f !== 32'h3404) begin errors++; $display("FAIL jr_pc: got %h expected %h", pc_f, 32'h3404); end
        // Jump + taken branch: jump target wins.
        jmp_op = 2'b01; br_op = 3'b001; rt_val = rs_val; imm16 = 16'h0010;
        #1;
        checks++; if (target_d !== 32'h3100) begin errors++; $display("FAIL jump_priority: got %h expected %h", target_d, 32'h3100); end
        // Wrap and misalignment via jr.
        br_op = 3'b000; jmp_op = 2'b10; rs_val = 32'hFFFF_FFFC;
        step();
        checks++; if (pc_f !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jr_top: got %h expected %h", pc_f, 32'hFFFF_FFFC); end
        jmp_op = 2'b00;
        step();
        checks++; if (pc_f !== 32'h0) begin errors++; $display("FAIL wrap: got %h expected %h", pc_f, 32'h0); end
        jmp_op = 2'b10; rs_val = 32'h3002;
        step();
        checks++; if (pc_f !== 32'h3002 || pc_misalign_f !== 1'b1) begin errors++; $display("FAIL misalign: got %h/%b expected %h/1", pc_f, pc_misalign_f, 32'h3002); end
        checks++; if (pc4_f !== 32'h3006) begin errors++; $display("FAIL misalign_pc4: got %h expected %h", pc4_f, 32'h3006); end
        idle();
        step();
        checks++; if (pc_misalign_f !== 1'b1) begin errors++; $display("FAIL misalign_keep: got %b expected 1", pc_misalign_f); end
    endtask

    task automatic test_stall_pending();
        pulse_reset();
        step();   // pc_f = 0x3004
        pc4_d = 32'h3008; imm16 = 16'h000E; rs_val = 32'd9; rt_val = 32'd9;
        stall = 1'b1; br_op = 3'b001;
        step();
        checks++; if (pc_f !== 32'h3004) begin errors++; $display("FAIL stall_hold1: got %h expected %h", pc_f, 32'h3004); end
        br_op = 3'b000;
        step();
        step();
        checks++; if (pc_f !== 32'h3004) begin errors++; $display("FAIL stall_hold3: got %h expected %h", pc_f, 32'h3004); end
        stall = 1'b0;
        step();
        checks++; if (pc_f !== 32'h3040) begin errors++; $display("FAIL pend_apply: got %h expected %h", pc_f, 32'h3040); end
        step();
        checks++; if (pc_f !== 32'h3044) begin errors++; $display("FAIL pend_clear: got %h expected %h", pc_f, 32'h3044); end
        // Second round: a new redirect on the release cycle overrides.
        stall = 1'b1; br_op = 3'b001; imm16 = 16'h000E;
        step();
        br_op = 3'b000;
        step();
        stall = 1'b0; br_op = 3'b001; imm16 = 16'h001E;
        step();
        checks++; if (pc_f !== 32'h3080) begin errors++; $display("FAIL pend_override: got %h expected %h", pc_f, 32'h3080); end
        br_op = 3'b000;
        step();
        checks++; if (pc_f !== 32'h3084) begin errors++; $display("FAIL override_clear: got %h expected %h", pc_f, 32'h3084); end
        // Reset while a redirect is parked discards it.
        stall = 1'b1; br_op = 3'b001; imm16 = 16'h000E;
        step();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (pc_f !== 32'h3000) begin errors++; $display("FAIL reset_in_stall: got %h expected %h", pc_f, 32'h3000); end
        reset_n = 1'b1; idle();
        step();
        checks++; if (pc_f !== 32'h3004) begin errors++; $display("FAIL reset_discard: got %h expected %h", pc_f, 32'h3004); end
    endtask

    task automatic test_stats();
        pulse_reset();
        pc4_d = 32'h3008; imm16 = 16'h000E; rs_val = 32'd3; rt_val = 32'd3;
        stall = 1'b1; br_op = 3'b001;
        step();
        step();
        stall = 1'b0;
        step();
        step();
        step();
        rt_val = 32'd4;
        step();
`ifdef NPC_BRANCH_STATS_EN
        checks++; if (stat_branches !== 16'd4 || stat_taken !== 16'd3) begin errors++; $display("FAIL stats_count: got %0d/%0d expected 4/3", stat_branches, stat_taken); end
        checks++; if (s_stat_branches !== 2'd3 || s_stat_taken !== 2'd3) begin errors++; $display("FAIL stats_sat4: got %0d/%0d expected 3/3", s_stat_branches, s_stat_taken); end
        step();
        checks++; if (stat_branches !== 16'd5 || stat_taken !== 16'd3) begin errors++; $display("FAIL stats_count5: got %0d/%0d expected 5/3", stat_branches, stat_taken); end
        checks++; if (s_stat_branches !== 2'd3 || s_stat_taken !== 2'd3) begin errors++; $display("FAIL stats_sat5: got %0d/%0d expected 3/3", s_stat_branches, s_stat_taken); end
`else
        step();
        checks++; if (stat_branches !== 16'd0 || stat_taken !== 16'd0) begin errors++; $display("FAIL stats_off: got %0d/%0d expected 0/0", stat_branches, stat_taken); end
        checks++; if (s_stat_branches !== 2'd0 || s_stat_taken !== 2'd0) begin errors++; $display("FAIL stats_off_sat: got %0d/%0d expected 0/0", s_stat_branches, s_stat_taken); end
`endif
        checks++; if (s_pc_f !== pc_f || s_pc4_f !== pc4_f || s_target_d !== target_d || s_link_d !== link_d || s_redirect_d !== redirect_d || s_pc_misalign_f !== pc_misalign_f) begin errors++; $display("FAIL sat_instance_path: got %h expected %h", s_pc_f, pc_f); end
        idle();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed();
        test_jumps();
        test_stall_pending();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish before 50000ns");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
